mem_access_ctrl: RTL and testbench

//   Initiator for the single-port data memory (comb. read, sync write). Accepts load / store /

---
 rtl/mem_access_ctrl_pkg.sv | 25 ++
 rtl/mem_access_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared constants for the data-memory access controller: default memory
//   geometry, request opcode encodings and FSM state encodings.
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  // Default memory geometry.
  localparam int unsigned ADDR_WIDTH   = 10;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned MEMORY_DEPTH = 1024;

  // Request opcodes. 2'b11 is reserved and rejected with resp_err.
  localparam logic [1:0] MEM_OP_LOAD  = 2'b00;
  localparam logic [1:0] MEM_OP_STORE = 2'b01;
  localparam logic [1:0] MEM_OP_FILL  = 2'b10;

  // FSM states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_STORE = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage : mem_access_ctrl_pkg

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator for a single-port data memory (combinational read, synchronous
//   write). Accepts load / store / fill requests over valid/ready, drives the
//   memory port and returns exactly one response per accepted request.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_op          00 load, 01 store, 10 fill, 11 illegal
//   req_addr        word address (fill: start address)
//   req_wdata       store data / fill pattern
//   req_len         fill word count
//   resp_valid/ready response handshake; response held until accepted
//   resp_rdata      load data, zero otherwise
//   resp_err        request rejected, memory untouched
//   mem_*           memory port (write_en, address, data_in, read_data)
//   busy            controller not idle
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH,
  parameter int unsigned DEPTH  = MEMORY_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state_q,        state_d;
  logic              req_ready_q,    req_ready_d;
  logic              resp_valid_q,   resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q,   resp_rdata_d;
  logic              resp_err_q,     resp_err_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic [ADDR_W-1:0] mem_address_q,  mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q,  mem_data_in_d;
  logic [ADDR_W-1:0] fill_left_q,    fill_left_d;   // fill writes remaining after the current one
  logic              busy_q,         busy_d;

  logic              accept;
  logic [ADDR_W:0]   fill_end;

  assign accept = req_valid & req_ready_q;

  // One bit wider than the address so start+len never wraps in the check.
  assign fill_end = {1'b0, req_addr} + {1'b0, req_len};

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // (which would infer a latch); holding the flop value is the default.
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    mem_write_en_d = 1'b0;
    mem_address_d  = mem_address_q;
    mem_data_in_d  = mem_data_in_q;
    fill_left_d    = fill_left_q;

    case (state_q)
      ST_IDLE: begin
        // req_ready comes up on the first edge after reset release.
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          case (req_op)
            MEM_OP_LOAD: begin
              mem_address_d = req_addr;
              state_d       = ST_LOAD;
            end
            MEM_OP_STORE: begin
              mem_write_en_d = 1'b1;
              mem_address_d  = req_addr;
              mem_data_in_d  = req_wdata;
              state_d        = ST_STORE;
            end
            MEM_OP_FILL: begin
              if (fill_end > DEPTH_EXT) begin
                resp_err_d   = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
              end else if (req_len == '0) begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
              end else begin
                mem_write_en_d = 1'b1;
                mem_address_d  = req_addr;
                mem_data_in_d  = req_wdata;
                fill_left_d    = req_len - ADDR_W'(1);
                state_d        = ST_FILL;
              end
            end
            default: begin
              resp_err_d   = 1'b1;
              resp_valid_d = 1'b1;
              state_d      = ST_RESP;
            end
          endcase
        end
      end

      ST_LOAD: begin
        // Memory read is combinational on mem_address, valid this cycle.
        resp_rdata_d = mem_read_data;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_STORE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_FILL: begin
        if (fill_left_q == '0) begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          mem_write_en_d = 1'b1;
          mem_address_d  = mem_address_q + ADDR_W'(1);
          fill_left_d    = fill_left_q - ADDR_W'(1);
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
      fill_left_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      mem_write_en_q <= mem_write_en_d;
      mem_address_q  <= mem_address_d;
      mem_data_in_q  <= mem_data_in_d;
      fill_left_q    <= fill_left_d;
      busy_q         <= busy_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_in_q;
  assign busy         = busy_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl with a behavioural single-port memory
//   (combinational read, synchronous write) and a write log.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] req_len;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_write_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  logic [DW-1:0] mem [DEPTH];
  int            wr_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_len       (req_len),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_write_en  (mem_write_en),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_read_data (mem_read_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address] <= mem_data_in;
      wr_log.push_back(int'(mem_address));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response, optionally hold resp_ready low
  // for 'hold' cycles checking stability, then consume it.
  // lat = number of cycles after the accept edge until resp_valid is seen.
  task automatic transact(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [AW-1:0] len,
                          input int hold, output logic [DW-1:0] rdata,
                          output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_len   = len;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    // Scramble request fields: they must not be re-sampled after accept.
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_len   = AW'($urandom);
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", 32'(resp_rdata), 32'(rdata));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    bit            saw_valid;

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3 + 1);
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_len    = '0;
    resp_ready = 1'b0;

    // Reset state.
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_write_en", 32'(mem_write_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_req_ready", 32'(req_ready), 32'd1);
    check("rst_release_addr", 32'(mem_address), 32'd0);

    // Store 0x5A @0x010.
    wr_log.delete();
    transact(2'b01, 10'h010, 8'h5A, 10'd0, 0, rd, er, lat);
    check("store_latency", 32'(lat), 32'd2);
    check("store_err", 32'(er), 32'd0);
    check("store_rdata", 32'(rd), 32'd0);
    check("store_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) check("store_addr", 32'(wr_log[0]), 32'h010);
    check("store_mem", 32'(mem[10'h010]), 32'h5A);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);

    // Load @0x010.
    wr_log.delete();
    transact(2'b00, 10'h010, 8'h00, 10'd0, 0, rd, er, lat);
    check("load_latency", 32'(lat), 32'd2);
    check("load_rdata", 32'(rd), 32'h5A);
    check("load_err", 32'(er), 32'd0);
    check("load_writes", 32'(wr_log.size()), 32'd0);

    // Fill 0x100 len 4 pattern 0xFF.
    wr_log.delete();
    transact(2'b10, 10'h100, 8'hFF, 10'd4, 0, rd, er, lat);
    check("fill_latency", 32'(lat), 32'd5);
    check("fill_err", 32'(er), 32'd0);
    check("fill_rdata", 32'(rd), 32'd0);
    check("fill_writes", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      check("fill_first_addr", 32'(wr_log[0]), 32'h100);
      check("fill_last_addr", 32'(wr_log[3]), 32'h103);
    end
    transact(2'b00, 10'h0FF, 8'h00, 10'd0, 0, rd, er, lat);
    check("load_0ff", 32'(rd), 32'hFE);
    transact(2'b00, 10'h100, 8'h00, 10'd0, 0, rd, er, lat);
    check("load_100", 32'(rd), 32'hFF);
    transact(2'b00, 10'h103, 8'h00, 10'd0, 0, rd, er, lat);
    check("load_103", 32'(rd), 32'hFF);
    transact(2'b00, 10'h104, 8'h00, 10'd0, 0, rd, er, lat);
    check("load_104", 32'(rd), 32'h0D);

    // Fill out of range: DEPTH-2 len 3.
    wr_log.delete();
    transact(2'b10, 10'(DEPTH - 2), 8'h77, 10'd3, 0, rd, er, lat);
    check("fill_oor_err", 32'(er), 32'd1);
    check("fill_oor_latency", 32'(lat), 32'd1);
    check("fill_oor_writes", 32'(wr_log.size()), 32'd0);

    // Fill exactly to the end: DEPTH-2 len 2.
    wr_log.delete();
    transact(2'b10, 10'(DEPTH - 2), 8'h11, 10'd2, 0, rd, er, lat);
    check("fill_edge_err", 32'(er), 32'd0);
    check("fill_edge_latency", 32'(lat), 32'd3);
    check("fill_edge_writes", 32'(wr_log.size()), 32'd2);
    check("fill_edge_mem", 32'(mem[DEPTH - 1]), 32'h11);

    // Fill len 0.
    wr_log.delete();
    transact(2'b10, 10'h050, 8'h99, 10'd0, 0, rd, er, lat);
    check("fill_len0_latency", 32'(lat), 32'd1);
    check("fill_len0_err", 32'(er), 32'd0);
    check("fill_len0_writes", 32'(wr_log.size()), 32'd0);

    // Illegal opcode.
    wr_log.delete();
    transact(2'b11, 10'h055, 8'h77, 10'd0, 0, rd, er, lat);
    check("illegal_err", 32'(er), 32'd1);
    check("illegal_rdata", 32'(rd), 32'd0);
    check("illegal_writes", 32'(wr_log.size()), 32'd0);

    // Response back-pressure: hold resp_ready low for 5 cycles.
    transact(2'b00, 10'h010, 8'h00, 10'd0, 5, rd, er, lat);
    check("hold_load_rdata", 32'(rd), 32'h5A);
    check("hold_post_valid", 32'(resp_valid), 32'd0);

    // Reset during fill 0x200 len 8 after 3 writes.
    wr_log.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 10'h200;
    req_wdata = 8'h3C;
    req_len   = 10'd8;
    check("pre_fill_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_write_en", 32'(mem_write_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_addr", 32'(mem_address), 32'd0);
    check("midrst_data", 32'(mem_data_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_valid |= resp_valid;
    end
    check("midrst_no_resp", 32'(saw_valid), 32'd0);
    check("midrst_writes", 32'(wr_log.size()), 32'd3);
    check("midrst_mem_200", 32'(mem[10'h200]), 32'h3C);
    check("midrst_mem_202", 32'(mem[10'h202]), 32'h3C);
    check("midrst_mem_203", 32'(mem[10'h203]), 32'h0A);
    check("midrst_req_ready", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_access_ctrl
